// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative radix-2 multiply/divide unit for the pipelined MIPS core.
//   Owns HI/LO and executes MULTU/MULT/DIVU/DIV. It also supports direct
//   HI/LO writes (MTHI/MTLO) and aborts an operation on a pipeline flush.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start, op      launch op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV) from IDLE
//   a, b           rs / rt operands, sampled only when start is accepted
//   flush          abort the in-flight operation; HI/LO are left untouched
//   hi_we, lo_we   MTHI / MTLO strobes, honoured only in IDLE with start=0
//   wdata          MTHI / MTLO data
//   busy           an operation is in flight (RUN or FIX)
//   done           one-cycle pulse; HI/LO were just written with a result
//   hi, lo         HI / LO registers
//
// Handshake: start is a single-cycle request with no ready. It is taken
// only when the unit is idle (busy=0) and flush=0. It is silently dropped
// otherwise, so the hazard unit must hold off new mult/div while busy=1.
//
// Timing: the edge that accepts start moves the FSM to RUN with the
// counter at WIDTH. RUN performs WIDTH iterations. FIX applies the sign
// correction and writes HI/LO on its exit edge, and done is high in the
// following (IDLE) cycle. During that cycle a new start is accepted.

module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [CNTW-1:0]  cnt_q,     cnt_d;
  logic             is_div_q,  is_div_d;
  logic             neg_q,     neg_d;      // product / quotient negated
  logic             rem_neg_q, rem_neg_d;  // remainder takes sign of a
  logic             div0_q,    div0_d;     // divide by zero
  logic [WIDTH-1:0] opnd_q,    opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] work_hi_q, work_hi_d;  // accumulator / partial remainder
  logic [WIDTH-1:0] work_lo_q, work_lo_d;  // multiplier / dividend -> quotient
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic             done_q,    done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    // Operand magnitudes; op[0] selects the signed variants.
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;

    // Shift-add step. The carry out of the add becomes the new top bit,
    // and the bit leaving the accumulator enters the multiplier register.
    mul_sum = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : '0)};

    // Restoring divide step. The shifted remainder needs WIDTH+1 bits.
    // When it is >= divisor, the difference is below the divisor, so it
    // fits in WIDTH bits.
    rem_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = rem_shift >= {1'b0, opnd_q};
    div_diff  = rem_shift[WIDTH-1:0] - opnd_q;

    // Sign correction. With b=0 the engine leaves remainder=|a|, so the
    // "sign of a" fix rebuilds the original a. Only LO needs forcing.
    prod_raw = {work_hi_q, work_lo_q};
    prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = div0_q ? '1 : (neg_q ? (~work_lo_q + 1'b1) : work_lo_q);
    rem_fix  = rem_neg_q ? (~work_hi_q + 1'b1) : work_hi_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d   = S_RUN;
          cnt_d     = CNTW'(WIDTH);
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = op[1] & (b == '0);
          opnd_d    = op[1] ? b_mag : a_mag;
          work_lo_d = op[1] ? a_mag : b_mag;
          work_hi_d = '0;
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            work_hi_d = div_ge ? div_diff : rem_shift[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
          end else begin
            work_hi_d = mul_sum[WIDTH:1];
            work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Directed and random stimulus for mips_muldiv_unit (WIDTH=32).
//   Expected HI/LO come from plain 64-bit arithmetic in the model function.
//   Inputs are driven and outputs sampled on the falling clock edge.

module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {HI, LO}.
  function automatic logic [2*W-1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx, sy, p, q, r;
    logic [2*W-1:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = {32'd0, x} * {32'd0, y};
      2'd1: begin
        p   = sx * sy;
        res = p;
      end
      2'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
      default: begin
        if (y == 0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver: call at a falling edge. Returns one falling edge later, after
  // the accepting rising edge, with the operand inputs scrambled.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Waits for done. e0 is the number of rising edges already seen since
  // start was raised. Returns at the falling edge of the done cycle.
  task automatic wait_done(input string tag, input int e0);
    int edges;
    int bcyc;
    logic [2*W-1:0] e;
    edges = e0;
    bcyc  = e0 - 1;
    while (!done && edges < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
      edges++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_latency"}, edges, 34);
    chk({tag, "_busy_cycles"}, bcyc, 33);
    chk({tag, "_busy_in_done"}, busy, 1'b0);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, hi, e[2*W-1:W]);
      chk({tag, "_lo"}, lo, e[W-1:0]);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(o, x, y, 1'b1);
    wait_done(tag, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic write_hilo(input bit wh, input bit wl, input logic [W-1:0] d);
    hi_we = wh;
    lo_we = wl;
    wdata = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  initial begin
    logic [W-1:0] hi_save, lo_save, ra, rb;
    logic [1:0]   ro;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic and corner cases
    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    run_op("mult_neg", 2'd1, 32'hFFFF_FFF9, 32'd3);
    run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'd2, 32'h0000_1234, 32'd0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'd3, 32'hFFFF_FF00, 32'd0);

    // MTHI / MTLO in IDLE
    write_hilo(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    lo_save = lo;
    chk("mthi_lo_kept", lo, lo_save);
    write_hilo(1'b0, 1'b1, 32'hCAFE_F00D);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

    // MTHI while busy is ignored
    start_op(2'd0, 32'd100, 32'd200, 1'b1);
    repeat (2) @(negedge clk);
    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    chk("mthi_busy_hi", hi, 32'hDEAD_BEEF);
    wait_done("mthi_busy", 4);
    @(negedge clk);

    // Flush and start in the same IDLE cycle: start ignored
    start = 1'b1;
    flush = 1'b1;
    op    = 2'd0;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_idle_busy", busy, 1'b0);

    // Flush at RUN iteration 5
    hi_save = hi;
    lo_save = lo;
    start_op(2'd0, 32'd5, 32'd6, 1'b0);
    repeat (4) @(negedge clk);
    chk("flush_pre_busy", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_done", done, 1'b0);
    watch_no_done("flush_no_done", 40);
    chk("flush_hi", hi, hi_save);
    chk("flush_lo", lo, lo_save);

    // Start while busy is ignored
    start_op(2'd0, 32'd5, 32'd6, 1'b1);
    repeat (3) @(negedge clk);
    chk("ign_busy", busy, 1'b1);
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd1000;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_start", 5);

    // Back-to-back: new start raised in the done cycle
    start_op(2'd2, 32'd1000, 32'd7, 1'b1);
    wait_done("b2b_first", 1);
    start_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("b2b_second", 1);
    @(negedge clk);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    // Reset in the middle of RUN
    write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("pre_reset_hi", hi, 32'hA5A5_A5A5);
    start_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_hi", hi, '0);
    chk("midreset_lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midreset_no_done", 40);
    chk("midreset_hi_after", hi, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
